grn_attractor_ctrl: RTL and testbench

GRN_ATTRACTOR_CTRL -- requirements
Module: grn_attractor_ctrl

---
 rtl/grn_pkg.sv | 16 +
 rtl/grn_attractor_ctrl_if.sv | 28 ++
 rtl/grn_state_cmp.sv | 10 +
 rtl/grn_attractor_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_grn_attractor_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/grn_pkg.sv
// Shared types and defaults for the gene-regulatory-network attractor controller.
package grn_pkg;

    // Default width of the step/period counters and of the result index fields.
    localparam int CNT_W_DEF = 32;

    // Controller phases: reload the nodes, run tortoise/hare, then measure the cycle.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLOYD  = 3'd2,
        S_PERIOD = 3'd3,
        S_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/grn_attractor_ctrl_if.sv
// Result bundle of the attractor controller.
// Handshake: the controller raises res_valid and holds it, together with
// meet_idx/period/attractor/timeout, unchanged until a cycle in which
// res_ready is also high; that cycle completes the transfer. res_ready is
// ignored whenever res_valid is low.
interface grn_attractor_ctrl_if
    import grn_pkg::*;
#(
    parameter int N_NODES = 188,
    parameter int CNT_W   = CNT_W_DEF
);
    logic               res_valid;
    logic               res_ready;
    logic [CNT_W-1:0]   meet_idx;
    logic [CNT_W-1:0]   period;
    logic [N_NODES-1:0] attractor;
    logic               timeout;

    modport master (
        output res_valid, meet_idx, period, attractor, timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid, meet_idx, period, attractor, timeout,
        output res_ready
    );
endinterface

// File: rtl/grn_state_cmp.sv
// Full-width equality of two network states.
module grn_state_cmp #(
    parameter int N_NODES = 188
) (
    input  logic [N_NODES-1:0] i_a,
    input  logic [N_NODES-1:0] i_b,
    output logic               o_eq
);
    assign o_eq = (i_a == i_b);
endmodule

// File: rtl/grn_attractor_ctrl.sv
// Attractor finder: drives two copies of a synchronous network with Floyd's
// tortoise/hare stepping, latches the meeting state, then counts hare steps
// until that state recurs to obtain the cycle length.
module grn_attractor_ctrl
    import grn_pkg::*;
#(
    parameter int N_NODES   = 188,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_STEPS = 2**20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output state_t             o_dbg_state,
    grn_attractor_ctrl_if.master res
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_k;
    logic [CNT_W-1:0]   r_p;
    logic [N_NODES-1:0] r_init_state;
    logic [N_NODES-1:0] r_attractor;
    logic [CNT_W-1:0]   r_meet_idx;
    logic [CNT_W-1:0]   r_period;
    logic               r_timeout;

    logic w_eq_floyd;
    logic w_eq_period;
    logic w_meet;
    logic w_floyd_to;
    logic w_per_done;
    logic w_per_to;
    logic w_start_s0;
    logic w_start_s1;
    logic w_reset_nos;
    logic w_busy;
    logic w_res_valid;

    grn_state_cmp #(.N_NODES(N_NODES)) u_cmp_floyd (
        .i_a  (s0_vec),
        .i_b  (s1_vec),
        .o_eq (w_eq_floyd)
    );

    grn_state_cmp #(.N_NODES(N_NODES)) u_cmp_period (
        .i_a  (s1_vec),
        .i_b  (r_attractor),
        .o_eq (w_eq_period)
    );

    // Odd k is skipped: after one strobe both copies hold f(init) trivially.
    assign w_meet     = !r_k[0] && (r_k[CNT_W-1:1] != '0) && w_eq_floyd;
    assign w_floyd_to = (r_k == MAX_CNT);
    assign w_per_done = (r_p != '0) && w_eq_period;
    assign w_per_to   = (r_p == MAX_CNT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobes; a strobe is issued in the same cycle its counter
    // advances, so k and p always equal the steps the nodes have absorbed.
    always_comb begin
        w_next      = r_state;
        w_start_s0  = 1'b0;
        w_start_s1  = 1'b0;
        w_reset_nos = 1'b0;
        w_busy      = 1'b1;
        w_res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_reset_nos = 1'b1;
                w_next      = S_FLOYD;
            end
            S_FLOYD: begin
                if (w_meet) begin
                    w_next = S_PERIOD;
                end else if (w_floyd_to) begin
                    w_next = S_RESULT;
                end else begin
                    w_start_s0 = 1'b1;
                    w_start_s1 = 1'b1;
                end
            end
            S_PERIOD: begin
                if (w_per_done || w_per_to) begin
                    w_next = S_RESULT;
                end else begin
                    w_start_s1 = 1'b1;
                end
            end
            S_RESULT: begin
                w_res_valid = 1'b1;
                if (res.res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Counters and result registers; counters are checked against the limit before incrementing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k          <= '0;
            r_p          <= '0;
            r_init_state <= '0;
            r_attractor  <= '0;
            r_meet_idx   <= '0;
            r_period     <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_init_state <= init_vec;
                        r_attractor  <= '0;
                        r_meet_idx   <= '0;
                        r_period     <= '0;
                        r_timeout    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_k <= '0;
                end
                S_FLOYD: begin
                    if (w_meet) begin
                        r_attractor <= s1_vec;
                        r_meet_idx  <= r_k >> 1;
                        r_p         <= '0;
                    end else if (w_floyd_to) begin
                        r_timeout  <= 1'b1;
                        r_meet_idx <= r_k >> 1;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_PERIOD: begin
                    if (w_per_done) begin
                        r_period <= r_p;
                    end else if (w_per_to) begin
                        r_timeout <= 1'b1;
                        r_period  <= r_p;
                    end else begin
                        r_p <= r_p + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign reset_nos     = w_reset_nos;
    assign start_s0      = w_start_s0;
    assign start_s1      = w_start_s1;
    assign busy          = w_busy;
    assign init_state    = r_init_state;
    assign o_dbg_state   = r_state;
    assign res.res_valid = w_res_valid;
    assign res.meet_idx  = r_meet_idx;
    assign res.period    = r_period;
    assign res.attractor = r_attractor;
    assign res.timeout   = r_timeout;

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: a behavioural two-copy node network feeds
// s0/s1, table-driven runs cover several network functions, and hand-written
// sequences cover ignored start, result back-pressure and mid-run reset.
module tb_grn_attractor_ctrl;
  import grn_pkg::*;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int MS = 8;
  localparam int W  = 1 + N + CW + CW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] init_vec = '0;
  logic [N-1:0] s0_vec;
  logic [N-1:0] s1_vec;
  logic         reset_nos;
  logic [N-1:0] init_state;
  logic         start_s0;
  logic         start_s1;
  logic         busy;
  state_t       dbg_state;

  grn_attractor_ctrl_if #(.N_NODES(N), .CNT_W(CW)) res_if ();

  grn_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .init_vec    (init_vec),
    .s0_vec      (s0_vec),
    .s1_vec      (s1_vec),
    .reset_nos   (reset_nos),
    .init_state  (init_state),
    .start_s0    (start_s0),
    .start_s1    (start_s1),
    .busy        (busy),
    .o_dbg_state (dbg_state),
    .res         (res_if.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  // network model: 0 identity, 1 count mod 4, 2 transient 0-1-2-3-2, 3 ring mod 16
  int mode = 0;

  function automatic logic [N-1:0] f_next(input int md, input logic [N-1:0] x);
    case (md)
      0:       return x;
      1:       return {2'b00, 2'(x[1:0] + 2'd1)};
      2:       return (x == 4'd3) ? 4'd2 : 4'(x + 4'd1);
      default: return 4'(x + 4'd1);
    endcase
  endfunction

  logic [N-1:0] n0, n1;
  logic         par;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n0 <= '0; n1 <= '0; par <= 1'b0;
    end else if (reset_nos) begin
      n0 <= init_state; n1 <= init_state; par <= 1'b0;
    end else begin
      if (start_s1) n1 <= f_next(mode, n1);
      if (start_s0) begin
        if (!par) n0 <= f_next(mode, n0);
        par <= ~par;
      end
    end
  end
  assign s0_vec = n0;
  assign s1_vec = n1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    int           md;
    logic [N-1:0] init;
    logic [CW-1:0] meet;
    logic [CW-1:0] per;
    logic [N-1:0] attr;
    logic         to;
    int           cyc;
  } vec_t;

  vec_t vecs[4];

  // driver tasks
  task automatic start_run(input vec_t v);
    start    = 1'b1;
    init_vec = v.init;
    mode     = v.md;
    exp_q.push_back({v.to, v.attr, v.meet, v.per});
  endtask

  task automatic wait_result(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (res_if.res_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_state(input state_t s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (dbg_state == s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_result(input string nm, output logic [W-1:0] e);
    if (exp_q.size() == 0) begin
      check({nm, " queue"}, 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
      check({nm, " timeout"}, res_if.timeout, e[W-1]);
      check({nm, " meet_idx"}, res_if.meet_idx, e[2*CW-1 -: CW]);
      check({nm, " period"}, res_if.period, e[CW-1:0]);
      if (!e[W-1]) check({nm, " attractor"}, res_if.attractor, e[W-2 -: N]);
    end
  endtask

  task automatic accept(input string nm);
    res_if.res_ready = 1'b1;
    @(posedge clk); #1;
    res_if.res_ready = 1'b0;
    check({nm, " idle after accept"}, {res_if.res_valid, busy}, 2'b00);
  endtask

  initial begin
    int cyc;
    bit ok;
    int seen;
    logic [W-1:0] e;
    logic [N-1:0] fx;

    fx = 4'($urandom_range(0, 15));
    vecs[0] = '{md: 0, init: fx,   meet: 1, per: 1, attr: fx,   to: 1'b0, cyc: 7};
    vecs[1] = '{md: 1, init: 4'd0, meet: 4, per: 4, attr: 4'd0, to: 1'b0, cyc: 16};
    vecs[2] = '{md: 2, init: 4'd0, meet: 2, per: 2, attr: 4'd2, to: 1'b0, cyc: 10};
    vecs[3] = '{md: 3, init: 4'd0, meet: 4, per: 0, attr: 4'd0, to: 1'b1, cyc: 11};

    res_if.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset strobes", {reset_nos, start_s0, start_s1}, 3'b000);
    check("reset init_state", init_state, 0);
    check("reset result", {res_if.res_valid, res_if.timeout, res_if.attractor,
                           res_if.meet_idx, res_if.period}, 0);
    check("reset state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven runs
    for (int i = 0; i < 4; i++) begin
      start_run(vecs[i]);
      wait_result(cyc, ok);
      check($sformatf("vec%0d valid seen", i), ok, 1);
      check($sformatf("vec%0d latency", i), cyc, vecs[i].cyc);
      check($sformatf("vec%0d busy", i), busy, 1);
      check_result($sformatf("vec%0d", i), e);
      accept($sformatf("vec%0d", i));
    end

    // start during FLOYD is ignored; then hold off the result for 5 cycles
    start_run(vecs[1]);
    wait_state(S_FLOYD, ok);
    check("floyd reached", ok, 1);
    start = 1'b1;
    init_vec = 4'hA;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored start init_state", init_state, vecs[1].init);
    wait_result(cyc, ok);
    check("ignored start valid seen", ok, 1);
    check_result("ignored start", e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d valid", i), res_if.res_valid, 1);
      check($sformatf("hold%0d result", i),
            {res_if.timeout, res_if.meet_idx, res_if.period, res_if.attractor},
            {e[W-1], e[2*CW-1 -: CW], e[CW-1:0], e[W-2 -: N]});
    end
    accept("hold");

    // reset during PERIOD abandons the run
    start_run(vecs[1]);
    wait_state(S_PERIOD, ok);
    check("period reached", ok, 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst state", dbg_state, S_IDLE);
    check("midrst outputs", {res_if.res_valid, reset_nos, start_s0, start_s1,
                             init_state, res_if.timeout, res_if.attractor,
                             res_if.meet_idx, res_if.period}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (res_if.res_valid || busy) seen++;
    end
    check("midrst stays idle", seen, 0);

    // recovery run after reset
    start_run(vecs[2]);
    wait_result(cyc, ok);
    check("recover valid seen", ok, 1);
    check("recover latency", cyc, vecs[2].cyc);
    check_result("recover", e);
    accept("recover");

    check("queue drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
